// File: rtl/video_pkg.sv
// Shared video stream types for the pixel packer/unpacker pair.
// Wire byte order for a pixel is G, B, R, starting at the lowest byte lane.
package video_pkg;

    localparam int         BYTES_PER_PIXEL = 3;
    localparam int         WORD_BYTES      = 4;
    localparam logic [3:0] KEEP_ALL        = 4'hf;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {PH_A, PH_B, PH_C, PH_D} phase_t;

    typedef struct packed {
        pixel_t pix;
        logic   sof;
        logic   eol;
    } beat_t;

    // Three stream-order bytes to a pixel; the packer uses the inverse mapping.
    function automatic pixel_t bytes_to_pixel(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2);
        pixel_t p;
        p.g = b0;
        p.b = b1;
        p.r = b2;
        return p;
    endfunction

endpackage

// File: rtl/pixel_out_reg.sv
// Single registered valid/ready output stage carrying one pixel plus sof/eol.
module pixel_out_reg
    import video_pkg::*;
(
    input  logic  aclk,
    input  logic  aresetn,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  load,
    output logic  out_valid,
    input  logic  out_ready,
    output beat_t out_beat
);

    assign load = !out_valid || out_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_beat <= in_beat;
            end
        end
    end

endmodule

// File: rtl/unpacker.sv
// Unpacks 32-bit stream words (3 words = 4 pixels) into one 24-bit pixel per transfer.
// UNPACKER_STATS_EN adds frame_count/line_count outputs.
//
// state | meaning
// PH_A  | no residual bytes held
// PH_B  | one residual byte held (h0)
// PH_C  | two residual bytes held (h0,h1)
// PH_D  | three residual bytes held; emit them without taking a word
module unpacker
    import video_pkg::*;
#(
    parameter bit RESYNC_ON_SOF = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sof,
    output logic        eol,
    output logic        protocol_err
`ifdef UNPACKER_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] line_count
`endif
);

    phase_t                              phase, phase_nxt, eph;
    logic [BYTES_PER_PIXEL-1:0][7:0]     resid, resid_nxt;
    logic [WORD_BYTES-1:0][7:0]          lane;
    logic                                d_eol, d_eol_nxt;
    logic                                err_nxt;
    logic                                load, word_ready, accept;
    logic                                beat_valid;
    beat_t                               beat, out_beat;

    assign lane       = in_stream_tdata;
    assign word_ready = load && (phase != PH_D);
    assign accept     = in_stream_tvalid && word_ready;
    // Reset gates only the port so the flops never see aresetn as data.
    assign in_stream_tready = word_ready && aresetn;

    // A resynchronising tuser word is unpacked as if no bytes were held.
    assign eph = (RESYNC_ON_SOF && in_stream_tuser && (phase == PH_B || phase == PH_C))
                 ? PH_A : phase;

    always_comb begin
        phase_nxt  = phase;
        resid_nxt  = resid;
        d_eol_nxt  = d_eol;
        err_nxt    = protocol_err;
        beat_valid = 1'b0;
        beat       = '0;
        if (accept) begin
            beat_valid = 1'b1;
            beat.sof   = in_stream_tuser;
            if (in_stream_tkeep != KEEP_ALL || (in_stream_tuser && phase != PH_A)) begin
                err_nxt = 1'b1;
            end
            case (eph)
                PH_A: begin
                    beat.pix  = bytes_to_pixel(lane[0], lane[1], lane[2]);
                    resid_nxt = {8'h00, 8'h00, lane[3]};
                    phase_nxt = PH_B;
                end
                PH_B: begin
                    beat.pix  = bytes_to_pixel(resid[0], lane[0], lane[1]);
                    resid_nxt = {8'h00, lane[3], lane[2]};
                    phase_nxt = PH_C;
                end
                PH_C: begin
                    beat.pix  = bytes_to_pixel(resid[0], resid[1], lane[0]);
                    resid_nxt = {lane[3], lane[2], lane[1]};
                    phase_nxt = PH_D;
                    d_eol_nxt = in_stream_tlast;
                end
                default: ;
            endcase
            // Short line: close it on this pixel and drop the leftover bytes.
            if (in_stream_tlast && eph != PH_C) begin
                beat.eol  = 1'b1;
                phase_nxt = PH_A;
                resid_nxt = '0;
                err_nxt   = 1'b1;
            end
        end else if (phase == PH_D && load) begin
            beat_valid = 1'b1;
            beat.pix   = bytes_to_pixel(resid[0], resid[1], resid[2]);
            beat.eol   = d_eol;
            phase_nxt  = PH_A;
            d_eol_nxt  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase        <= PH_A;
            resid        <= '0;
            d_eol        <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            resid        <= resid_nxt;
            d_eol        <= d_eol_nxt;
            protocol_err <= err_nxt;
        end
    end

    pixel_out_reg u_out (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (beat_valid),
        .in_beat   (beat),
        .load      (load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_beat  (out_beat)
    );

    assign r   = out_beat.pix.r;
    assign g   = out_beat.pix.g;
    assign b   = out_beat.pix.b;
    assign sof = out_beat.sof;
    assign eol = out_beat.eol;

`ifdef UNPACKER_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
            line_count  <= '0;
        end else if (out_valid && out_ready) begin
            if (sof) begin
                frame_count <= frame_count + 16'd1;
                line_count  <= {15'd0, eol};
            end else if (eol) begin
                line_count  <= line_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unpacker.sv
// Self-checking bench for unpacker: directed test-plan streams plus random streams
// checked against a byte-queue model of the stream.
module tb_unpacker;

    localparam bit RESYNC = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] r;
        logic       sof;
        logic       eol;
    } pix_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] in_stream_tdata = '0;
    logic [3:0]  in_stream_tkeep = 4'hf;
    logic        in_stream_tlast = 1'b0;
    logic        in_stream_tuser = 1'b0;
    logic        in_stream_tvalid = 1'b0;
    logic        in_stream_tready;
    logic [7:0]  r, g, b;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sof, eol, protocol_err;
`ifdef UNPACKER_STATS_EN
    logic [15:0] frame_count, line_count;
`endif

    unpacker #(.RESYNC_ON_SOF(RESYNC)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (in_stream_tdata),
        .in_stream_tkeep  (in_stream_tkeep),
        .in_stream_tlast  (in_stream_tlast),
        .in_stream_tuser  (in_stream_tuser),
        .in_stream_tvalid (in_stream_tvalid),
        .in_stream_tready (in_stream_tready),
        .r                (r),
        .g                (g),
        .b                (b),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .sof              (sof),
        .eol              (eol),
        .protocol_err     (protocol_err)
`ifdef UNPACKER_STATS_EN
        ,
        .frame_count      (frame_count),
        .line_count       (line_count)
`endif
    );

    always #5 aclk = ~aclk;

    int          n_tests = 0;
    int          n_fail  = 0;
    word_t       words[$];
    pix_t        exp_q[$];
    logic [7:0]  held[$];
    bit          m_err;
    logic [15:0] m_fc, m_lc;
    int          ready_mode, valid_gap;
    int          stall_cnt, first_acc, last_pix;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic word_t mk(input logic [31:0] d, input logic u, input logic l);
        word_t w;
        w.data = d;
        w.keep = 4'hf;
        w.user = u;
        w.last = l;
        return w;
    endfunction

    // Stream model: bytes accumulate in a queue and leave three at a time.
    task automatic model_accept(input word_t w);
        int   n;
        pix_t p;
        if (w.keep != 4'hf) m_err = 1'b1;
        if (w.user && held.size() > 0) begin
            m_err = 1'b1;
            if (RESYNC) held.delete();
        end
        for (int k = 0; k < 4; k++) held.push_back(w.data[8*k +: 8]);
        n = held.size() / 3;
        for (int i = 0; i < n; i++) begin
            p.g   = held.pop_front();
            p.b   = held.pop_front();
            p.r   = held.pop_front();
            p.sof = w.user && (i == 0);
            p.eol = w.last && (i == n - 1);
            exp_q.push_back(p);
        end
        if (w.last && held.size() > 0) begin
            m_err = 1'b1;
            held.delete();
        end
    endtask

    task automatic do_reset();
        #2;
        aresetn = 1'b0;
        in_stream_tvalid = 1'b0;
        #1;
        chk("rst_tready", in_stream_tready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pix", {g, b, r, sof, eol}, 0);
        chk("rst_err", protocol_err, 0);
`ifdef UNPACKER_STATS_EN
        chk("rst_stats", {frame_count, line_count}, 0);
`endif
        held.delete();
        exp_q.delete();
        words.delete();
        m_err = 1'b0;
        m_fc = '0;
        m_lc = '0;
        ready_mode = 0;
        valid_gap = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic run_stream(input int budget);
        int    it;
        bit    pend;
        word_t cur;
        pix_t  p;
        it = 0;
        pend = 1'b0;
        cur = '0;
        stall_cnt = 0;
        first_acc = -1;
        last_pix = -1;
        while (it < budget && (words.size() > 0 || pend || exp_q.size() > 0)) begin
            @(negedge aclk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (it % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (!pend && words.size() > 0 && (valid_gap == 0 || $urandom_range(0, 3) != 0)) begin
                cur = words.pop_front();
                pend = 1'b1;
            end
            in_stream_tvalid = pend;
            in_stream_tdata  = cur.data;
            in_stream_tkeep  = cur.keep;
            in_stream_tuser  = cur.user;
            in_stream_tlast  = cur.last;
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", out_valid, 0);
                end else begin
                    chk("pixel", {6'd0, g, b, r, sof, eol}, {6'd0, exp_q[0]});
                    if (out_ready) begin
                        p = exp_q.pop_front();
                        if (p.sof) begin
                            m_fc = m_fc + 16'd1;
                            m_lc = '0;
                        end
                        if (p.eol) m_lc = m_lc + 16'd1;
                        last_pix = it;
                    end
                end
            end
            if (pend) begin
                if (in_stream_tready) begin
                    model_accept(cur);
                    pend = 1'b0;
                    if (first_acc < 0) first_acc = it;
                end else begin
                    stall_cnt++;
                end
            end
            it++;
        end
        @(negedge aclk);
        in_stream_tvalid = 1'b0;
        out_ready = 1'b1;
        chk("leftover", words.size() + int'(pend) + exp_q.size(), 0);
        repeat (3) begin
            @(negedge aclk);
            #1;
            chk("idle_valid", out_valid, 0);
        end
        chk("protocol_err", protocol_err, m_err);
`ifdef UNPACKER_STATS_EN
        chk("frame_count", frame_count, m_fc);
        chk("line_count", line_count, m_lc);
`endif
    endtask

    initial begin
        do_reset();

        // Two back-to-back lines, downstream always ready.
        words.push_back(mk(32'h44332211, 1'b1, 1'b0));
        words.push_back(mk(32'h88776655, 1'b0, 1'b0));
        words.push_back(mk(32'hCCBBAA99, 1'b0, 1'b1));
        words.push_back(mk(32'h44332211, 1'b0, 1'b0));
        words.push_back(mk(32'h88776655, 1'b0, 1'b0));
        words.push_back(mk(32'hCCBBAA99, 1'b0, 1'b1));
        run_stream(200);
        chk("latency_span", last_pix - first_acc, 8);
        chk("d_phase_stall", stall_cnt, 1);

        // out_ready toggling 1,0,1,0.
        do_reset();
        ready_mode = 1;
        words.push_back(mk(32'h44332211, 1'b1, 1'b0));
        words.push_back(mk(32'h88776655, 1'b0, 1'b0));
        words.push_back(mk(32'hCCBBAA99, 1'b0, 1'b1));
        run_stream(200);

        // tlast on the second word.
        do_reset();
        words.push_back(mk(32'h44332211, 1'b1, 1'b0));
        words.push_back(mk(32'h88776655, 1'b0, 1'b1));
        words.push_back(mk(32'hCCBBAA99, 1'b0, 1'b0));
        run_stream(200);

        // tuser arriving while two bytes are held.
        do_reset();
        words.push_back(mk(32'h44332211, 1'b1, 1'b0));
        words.push_back(mk(32'h88776655, 1'b0, 1'b0));
        words.push_back(mk(32'hF3F2F1F0, 1'b1, 1'b0));
        words.push_back(mk(32'h88776655, 1'b0, 1'b0));
        words.push_back(mk(32'hCCBBAA99, 1'b0, 1'b1));
        run_stream(200);

        // Reset pulsed while in phase B with a pixel stalled on the output.
        do_reset();
        @(negedge aclk);
        out_ready = 1'b0;
        in_stream_tdata = 32'h44332211;
        in_stream_tkeep = 4'hf;
        in_stream_tuser = 1'b1;
        in_stream_tlast = 1'b0;
        in_stream_tvalid = 1'b1;
        #1;
        chk("w0_ready", in_stream_tready, 1);
        @(negedge aclk);
        in_stream_tvalid = 1'b0;
        #1;
        chk("stalled_valid", out_valid, 1);
        chk("stalled_pix", {g, b, r, sof, eol}, {8'h11, 8'h22, 8'h33, 1'b1, 1'b0});
        do_reset();
        words.push_back(mk(32'h44332211, 1'b1, 1'b0));
        words.push_back(mk(32'h88776655, 1'b0, 1'b0));
        words.push_back(mk(32'hCCBBAA99, 1'b0, 1'b1));
        run_stream(200);

        // Two frames of two lines each.
        do_reset();
        ready_mode = 2;
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 2; l++) begin
                for (int k = 0; k < 3; k++) begin
                    words.push_back(mk($urandom, (l == 0 && k == 0), (k == 2)));
                end
            end
        end
        run_stream(500);
`ifdef UNPACKER_STATS_EN
        chk("frames_2x2", frame_count, 16'd2);
        chk("lines_2x2", line_count, 16'd2);
`endif

        // Random streams; the first is well formed, the rest carry protocol errors.
        for (int run = 0; run < 4; run++) begin
            do_reset();
            ready_mode = 2;
            valid_gap = 1;
            for (int i = 0; i < 60; i++) begin
                word_t w;
                w.data = $urandom;
                if (run == 0) begin
                    w.user = (i == 0);
                    w.last = (i % 3 == 2);
                    w.keep = 4'hf;
                end else begin
                    w.user = (i == 0) || ($urandom_range(0, 15) == 0);
                    w.last = ($urandom_range(0, 5) == 0);
                    w.keep = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'hf;
                end
                words.push_back(w);
            end
            run_stream(2000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
